// File: rtl/io_out_fifo_if.sv
// CPU I/O strobes plus the downstream valid/ready stream of the output FIFO.
// The shared io_data bus is a plain inout on the peripheral itself.
interface io_out_fifo_if;
    logic [3:0] io_addr;
    logic       io_oe;
    logic       io_we;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       full;
    logic       overflow;

    modport master (
        output io_addr, io_oe, io_we, out_ready,
        input  out_data, out_valid, full, overflow
    );

    modport slave (
        input  io_addr, io_oe, io_we, out_ready,
        output out_data, out_valid, full, overflow
    );
endinterface

// File: rtl/io_out_fifo.sv
// Memory-mapped output FIFO: CPU byte writes are queued and drained over a valid/ready stream.
// Optional accepted-push counter at STAT_ADDR+1 is enabled by defining IO_FIFO_WRCOUNT_EN.
module io_out_fifo #(
    parameter int         DEPTH     = 8,
    parameter logic [3:0] DATA_ADDR = 4'h0,
    parameter logic [3:0] STAT_ADDR = 4'h1
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [7:0]  io_data,
    io_out_fifo_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic       empty_s, full_s, wr_sel_s, ctl_sel_s;
    logic       push_s, drop_s, pop_s, flush_s, ovf_clr_s;
    logic [7:0] head_s, status_s, drv_val_s;
    logic       drv_en_s;

    assign empty_s   = (count_q == CW'(0));
    assign full_s    = (count_q == CW'(DEPTH));
    assign wr_sel_s  = bus.io_we && (bus.io_addr == DATA_ADDR);
    assign ctl_sel_s = bus.io_we && (bus.io_addr == STAT_ADDR);
    // Full is judged on pre-edge state, so a same-cycle pop never rescues a push.
    assign push_s    = wr_sel_s && !full_s;
    assign drop_s    = wr_sel_s && full_s;
    assign flush_s   = ctl_sel_s && io_data[6];
    assign ovf_clr_s = ctl_sel_s && io_data[7];
    assign pop_s     = !empty_s && bus.out_ready && !flush_s;

    assign head_s   = empty_s ? 8'h00 : mem_q[rd_ptr_q];
    assign status_s = {full_s, empty_s, ovf_q, 1'b0, 4'(count_q)};

    assign bus.out_data  = head_s;
    assign bus.out_valid = !empty_s;
    assign bus.full      = full_s;
    assign bus.overflow  = ovf_q;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush_s) begin
            wr_ptr_d = AW'(0);
            rd_ptr_d = AW'(0);
            count_d  = CW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= io_data;
        end
    end

`ifdef IO_FIFO_WRCOUNT_EN
    localparam logic [3:0] CNT_ADDR = STAT_ADDR + 4'd1;
    logic [7:0] wcnt_q, wcnt_d;

    // Saturating count of accepted pushes; dropped pushes do not count.
    always_comb begin
        wcnt_d = wcnt_q;
        if (flush_s) begin
            wcnt_d = 8'h00;
        end else if (push_s && (wcnt_q != 8'hFF)) begin
            wcnt_d = wcnt_q + 8'd1;
        end else begin
            wcnt_d = wcnt_q;
        end
    end

    // Push counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt_q <= 8'h00;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`endif

    // Read decode; a simultaneous write strobe or reset keeps the bus released.
    always_comb begin
        drv_en_s  = 1'b0;
        drv_val_s = 8'h00;
        if (reset && bus.io_oe && !bus.io_we) begin
            if (bus.io_addr == STAT_ADDR) begin
                drv_en_s  = 1'b1;
                drv_val_s = status_s;
            end else if (bus.io_addr == DATA_ADDR) begin
                drv_en_s  = 1'b1;
                drv_val_s = head_s;
`ifdef IO_FIFO_WRCOUNT_EN
            end else if (bus.io_addr == CNT_ADDR) begin
                drv_en_s  = 1'b1;
                drv_val_s = wcnt_q;
`endif
            end else begin
                drv_en_s = 1'b0;
            end
        end else begin
            drv_en_s = 1'b0;
        end
    end

    assign io_data = drv_en_s ? drv_val_s : 8'hzz;
endmodule

// File: tb/tb_io_out_fifo.sv
// Scoreboard bench for io_out_fifo: directed scenarios followed by random CPU/consumer traffic.
// A released bus is observed through pull-ups, so high-Z reads as 8'hFF.
module tb_io_out_fifo;
    localparam int         DEPTH = 8;
    localparam logic [3:0] DA    = 4'h0;
    localparam logic [3:0] SA    = 4'h1;
    localparam logic [3:0] CA    = 4'h2;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       tb_drv = 1'b0;
    logic [7:0] tb_val = 8'h00;
    wire  [7:0] io_data;

    io_out_fifo_if bus_if ();

    io_out_fifo #(.DEPTH(DEPTH), .DATA_ADDR(DA), .STAT_ADDR(SA)) dut (
        .clk     (clk),
        .reset   (reset),
        .io_data (io_data),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    assign io_data = tb_drv ? tb_val : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (io_data[g]);
    end

    int checks = 0;
    int errors = 0;

    // Reference state: queue contents, sticky overflow, accepted-push count.
    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic [7:0] m_cnt = 8'h00;

    // Per-cycle expectations handed from model to monitor.
    logic       chk_pending = 1'b0;
    logic       pop_now     = 1'b0;
    logic       exp_rd      = 1'b0;
    logic [7:0] exp_bus     = 8'h00;
    logic [7:0] pre_head    = 8'h00;
    int         pre_n       = 0;
    logic       pre_ovf     = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: evaluates the coming edge from pre-edge state and the driven inputs.
    initial begin
        forever begin
            @(negedge clk);
            chk_pending = 1'b0;
            pop_now     = 1'b0;
            if (reset) begin
                logic wr_d, ctl, flush;
                pre_n    = mq.size();
                pre_head = (pre_n > 0) ? mq[0] : 8'h00;
                pre_ovf  = m_ovf;
                exp_rd   = bus_if.io_oe && !bus_if.io_we;
                if (bus_if.io_addr == SA)
                    exp_bus = {(pre_n == DEPTH), (pre_n == 0), m_ovf, 1'b0, 4'(pre_n)};
                else if (bus_if.io_addr == DA)
                    exp_bus = pre_head;
`ifdef IO_FIFO_WRCOUNT_EN
                else if (bus_if.io_addr == CA)
                    exp_bus = m_cnt;
`endif
                else
                    exp_bus = 8'hFF;
                wr_d  = bus_if.io_we && (bus_if.io_addr == DA);
                ctl   = bus_if.io_we && (bus_if.io_addr == SA);
                flush = ctl && tb_val[6];
                pop_now = (pre_n > 0) && bus_if.out_ready && !flush;
                if (flush) begin
                    mq.delete();
                    m_cnt = 8'h00;
                end
                if (wr_d && (pre_n < DEPTH)) begin
                    mq.push_back(tb_val);
                    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                end else if (wr_d) begin
                    m_ovf = 1'b1;
                end
                if (ctl && tb_val[7]) m_ovf = 1'b0;
                chk_pending = 1'b1;
            end
        end
    end

    // Monitor: compares DUT outputs to the model and retires popped entries.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (chk_pending && reset) begin
                check("out_valid", {7'b0, bus_if.out_valid}, {7'b0, (pre_n != 0)});
                check("out_data", bus_if.out_data, pre_head);
                check("full", {7'b0, bus_if.full}, {7'b0, (pre_n == DEPTH)});
                check("overflow", {7'b0, bus_if.overflow}, {7'b0, pre_ovf});
                if (exp_rd) check("io_read", io_data, exp_bus);
                if (pop_now) void'(mq.pop_front());
            end
        end
    end

    task automatic cyc(input logic we, input logic [3:0] a, input logic [7:0] d,
                       input logic oe, input logic rdy);
        @(posedge clk);
        #1;
        bus_if.io_we     = we;
        bus_if.io_addr   = a;
        bus_if.io_oe     = oe;
        bus_if.out_ready = rdy;
        tb_val           = d;
        tb_drv           = we;
    endtask

    task automatic expect_bus(input logic [3:0] a, input logic [7:0] v, input string name);
        cyc(1'b0, a, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        check(name, io_data, v);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #3;
        reset = 1'b0;
        bus_if.io_we = 1'b0; tb_drv = 1'b0;
        bus_if.io_oe = 1'b1; bus_if.io_addr = DA; bus_if.out_ready = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        m_cnt = 8'h00;
        #1;
        check("rst_valid", {7'b0, bus_if.out_valid}, 8'h00);
        check("rst_data", bus_if.out_data, 8'h00);
        check("rst_full", {7'b0, bus_if.full}, 8'h00);
        check("rst_ovf", {7'b0, bus_if.overflow}, 8'h00);
        check("rst_bus_z", io_data, 8'hFF);
        @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    initial begin
        bus_if.io_we = 1'b0; bus_if.io_oe = 1'b0;
        bus_if.io_addr = 4'h0; bus_if.out_ready = 1'b0;
        reset = 1'b0;
        #1;
        check("init_valid", {7'b0, bus_if.out_valid}, 8'h00);
        check("init_data", bus_if.out_data, 8'h00);
        check("init_full", {7'b0, bus_if.full}, 8'h00);
        check("init_ovf", {7'b0, bus_if.overflow}, 8'h00);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;

        // In-order delivery with a ready consumer.
        cyc(1'b1, DA, 8'h01, 1'b0, 1'b1);
        cyc(1'b1, DA, 8'h01, 1'b0, 1'b1);
        cyc(1'b1, DA, 8'h02, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, DA, 8'h00, 1'b0, 1'b1);

        // Fill, then overflow.
        for (int i = 0; i < 8; i++) cyc(1'b1, DA, 8'h10 + 8'(i), 1'b0, 1'b0);
        expect_bus(SA, 8'h88, "stat_full");
        cyc(1'b1, DA, 8'h18, 1'b0, 1'b0);
        expect_bus(SA, 8'hA8, "stat_ovf");

        // Push while full alongside a pop is still dropped.
        cyc(1'b1, DA, 8'h55, 1'b0, 1'b1);
        expect_bus(SA, 8'h27, "stat_push_pop_full");
        expect_bus(DA, 8'h11, "head_after_pop");

        // Overflow clear, then flush.
        cyc(1'b1, SA, 8'h80, 1'b0, 1'b0);
        expect_bus(SA, 8'h07, "stat_ovf_clr");
        cyc(1'b1, SA, 8'h40, 1'b0, 1'b0);
        expect_bus(SA, 8'h40, "stat_flush");
        expect_bus(DA, 8'h00, "head_flush");

        // Reset in the middle of draining.
        cyc(1'b1, DA, 8'h31, 1'b0, 1'b0);
        cyc(1'b1, DA, 8'h32, 1'b0, 1'b0);
        cyc(1'b1, DA, 8'h33, 1'b0, 1'b0);
        cyc(1'b0, DA, 8'h00, 1'b0, 1'b1);
        reset_pulse();
        expect_bus(SA, 8'h40, "stat_after_rst");
        cyc(1'b1, DA, 8'hAA, 1'b0, 1'b0);
        expect_bus(DA, 8'hAA, "head_after_rst");
        cyc(1'b1, SA, 8'h40, 1'b0, 1'b0);

`ifdef IO_FIFO_WRCOUNT_EN
        for (int i = 0; i < 300; i++) cyc(1'b1, DA, 8'(i), 1'b0, 1'b1);
        cyc(1'b0, DA, 8'h00, 1'b0, 1'b1);
        expect_bus(CA, 8'hFF, "wrcount_sat");
        cyc(1'b1, SA, 8'h40, 1'b0, 1'b0);
        expect_bus(CA, 8'h00, "wrcount_flush");
`else
        expect_bus(CA, 8'hFF, "undecoded_z");
`endif

        // Random CPU traffic against a randomly stalling consumer.
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] a;
            a = ($urandom_range(0, 9) < 7) ? DA : 4'($urandom_range(1, 3));
            cyc(1'($urandom_range(0, 1)), a, 8'($urandom), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) != 0));
        end
        repeat (12) cyc(1'b0, DA, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_out_fifo.md
Name: io_out_fifo

Overview:
- Memory-mapped output peripheral on the computer's 4-bit-address I/O bus, directly downstream of the CPU's io_we writes.
- Captures bytes the CPU writes to its data port into a small FIFO.
- Exposes a status byte back on io_data, and drains the FIFO through a valid/ready stream to a consumer (LED driver, UART, bench monitor).
- Decouples CPU program speed from consumer speed; records overflow when the consumer stalls.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..8.
DATA_ADDR, 4'h0, io_addr of the data port.
STAT_ADDR, 4'h1, io_addr of the status/control port.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
io_data  inout  8  shared bus; driven only during a decoded read, otherwise high-Z.
io_addr  in  4  I/O port address from CPU.
io_oe  in  1  CPU read strobe.
io_we  in  1  CPU write strobe.
out_data  out  8  head-of-FIFO byte.
out_valid  out  1  FIFO non-empty.
out_ready  in  1  consumer accepts head this cycle.
full  out  1  count == DEPTH.
overflow  out  1  sticky: a push was dropped.

Behaviour:
- Reset (async assert, sync-safe release): rd/wr pointers and count = 0, out_valid = 0, out_data = 8'h00, full = 0, overflow = 0. io_data is high-Z. FIFO storage is not reset.
- count width: $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Push: at posedge when io_we && io_addr==DATA_ADDR && !full (pre-edge). Stores io_data at wr_ptr. out_valid rises the cycle after the push edge (1-cycle latency).
- Push while full is dropped: overflow <= 1. A pop in the same cycle does NOT rescue the push, because full is evaluated on pre-edge state.
- Pop: at posedge when out_valid && out_ready. out_ready while empty is ignored.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Control write: io_we && io_addr==STAT_ADDR.
  - bit7=1: clears overflow.
  - bit6=1: flush (pointers and count <= 0).
  - Flush beats a same-cycle pop.
  - Other bits are ignored.
- out_data = empty ? 8'h00 : mem[rd_ptr], combinational from registered state.
- Reads (combinational, io_oe && !io_we):
  - STAT_ADDR drives {full, empty, overflow, 1'b0, count[3:0]} (count zero-extended).
  - DATA_ADDR drives the head byte (8'h00 if empty) without popping.
  - Any other address: high-Z.
- io_oe && io_we together: the write is processed and the bus is NOT driven (no contention).
- Reset asserted mid-operation: all state clears immediately. Contents are lost; overflow is cleared.
- Non-decoded addresses: no state change.

Optional Feature:
- Macro IO_FIFO_WRCOUNT_EN.
- Defined:
  - Adds an 8-bit saturating counter of accepted pushes (sticks at 8'hFF; dropped pushes are not counted).
  - Counter is readable at address STAT_ADDR+1 (4-bit wrap) via io_oe.
  - Cleared by reset and by flush.
- Undefined: no counter; STAT_ADDR+1 is undecoded and the bus stays high-Z there.

Test Plan:
- Reset low, then release; CPU writes 8'h01, 8'h01, 8'h02 to DATA_ADDR with out_ready=1 -> out_valid pulses; consumer sees 01, 01, 02 in order; each byte is valid one cycle after its write edge.
- out_ready=0; write 8'h10..8'h17 -> full=1 and status read = 8'h88. A 9th write of 8'h18 -> overflow=1, data dropped, status = 8'hA8.
- Full FIFO; same-cycle write 8'h55 and pop -> 8'h10 popped, 8'h55 dropped, count=7, overflow=1.
- Write 8'h80 to STAT_ADDR -> overflow=0 with FIFO intact. Write 8'h40 -> empty, status = 8'h40, out_data = 8'h00.
- 3 bytes queued; pulse reset low mid-drain -> out_valid=0, count=0, io_data high-Z immediately. After release, a new write 8'hAA appears as the head.
- IO_FIFO_WRCOUNT_EN defined: 300 accepted pushes with concurrent drain -> read at STAT_ADDR+1 = 8'hFF. After flush it reads 8'h00. With the macro undefined, the same read leaves io_data = 8'hzz.
